difftest_commit_sched: RTL and testbench
========================================

Name: difftest_commit_sched

Overview:
- Sequencing buffer between the retire stage and the difftest commit interface.
- Accepts a multi-lane retire bundle each cycle and compacts the valid lanes in lane order into an in-order FIFO.
- Drains the FIFO one instruction per cycle over a valid/ready handshake, so the checker and trace logic see a strictly serialized commit stream.
- Back-pressures retire when space is short, flags protocol violations, and counts drained instructions.

Parameters:
- CONFIG_P_COMMIT_WIDTH, 1: log2 of retire lanes; W = 1<<CONFIG_P_COMMIT_WIDTH.
- CONFIG_P_FIFO_DEPTH, 3: log2 of FIFO entries; D = 1<<CONFIG_P_FIFO_DEPTH. Must satisfy CONFIG_P_FIFO_DEPTH >= CONFIG_P_COMMIT_WIDTH.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- i_valid  in  W  per-lane retire valid; any mask is allowed, including non-contiguous.
- i_pc  in  W*30  per-lane word PC; lane k occupies bits [k*30 +: 30].
- i_insn  in  W*32  per-lane instruction word.
- i_wen  in  W  per-lane register write enable.
- i_wnum  in  W*5  per-lane destination register number.
- i_wdata  in  W*32  per-lane write data.
- i_ready  out  1  bundle may be accepted this cycle.
- o_valid  out  1  head entry valid.
- o_pc  out  30  head PC (word address).
- o_insn  out  32  head instruction.
- o_wen  out  1  head write enable.
- o_wnum  out  5  head destination register.
- o_wdata  out  32  head write data.
- o_ready  in  1  consumer accepts head.
- o_overflow  out  1  sticky protocol-violation flag.
- o_cnt  out  32  count of drained instructions.

Behaviour:
- State:
  - D-entry array of {pc, insn, wen, wnum, wdata}.
  - rptr and wptr, each CONFIG_P_FIFO_DEPTH+1 bits.
  - count register, 0..D.
- Reset (rst=1 at posedge): rptr=wptr=0, count=0, o_overflow=0, o_cnt=0. Array contents are don't-care. Outputs the next cycle: o_valid=0, i_ready=1.
- Reset mid-operation discards all buffered entries. No partial drain occurs.
- i_ready = (D - count) >= W. It is derived only from the count register, with no combinational path from any input.
- Push:
  - Taken when i_ready=1 and |i_valid.
  - The n = popcount(i_valid) valid lanes are written in ascending lane index to slots wptr, wptr+1, ..., wptr+n-1 (mod D).
  - wptr advances by n. Invalid lanes consume no slot.
- Violation: if |i_valid while i_ready=0, the whole bundle is discarded (no partial write), o_overflow is set, and it stays set until rst.
- Pop:
  - o_valid = (count != 0).
  - o_* fields read combinationally from mem[rptr] (show-ahead).
  - On o_valid & o_ready, rptr advances by 1 and o_cnt increments.
  - o_cnt wraps from 0xFFFFFFFF to 0.
- o_* fields other than o_valid are don't-care when o_valid=0.
- Simultaneous push and pop: count_next = count + n - pop. The pop reads the pre-edge head, and a push never overwrites an unread slot, guaranteed by the i_ready rule.
- Latency: an entry pushed at edge t is visible on o_valid starting the cycle after edge t. There is no empty-FIFO bypass.
- Pointer wrap: the index uses the low CONFIG_P_FIFO_DEPTH bits. Full/empty are decided by count only.
- Ordering: output order equals retire order, meaning bundle order first and then lane order within a bundle. Throughput is one drain per cycle.
- With W=1 and D>=2, the block degenerates to a plain FIFO with identical rules.

Test Plan:
1. Reset then idle, W=2, D=8: after rst, o_valid=0, i_ready=1, o_cnt=0, o_overflow=0 for 10 cycles.
2. Compaction:
   - Stimulus: one bundle i_valid=2'b10, lane1 pc=0x100, insn=0xDEADBEEF, wen=1, wnum=3, wdata=5; o_ready=1.
   - Required: next cycle o_valid=1, o_pc=0x100, o_wnum=3, o_wdata=5.
   - Following cycle: o_valid=0, o_cnt=1.
3. Ordering:
   - Stimulus: bundles {A,B}, then {C,–}, then {D,E} on consecutive cycles; o_ready=1.
   - Required: output sequence A,B,C,D,E on 5 consecutive cycles; o_cnt=5.
4. Backpressure:
   - Stimulus: o_ready=0, push full 2-lane bundles.
   - Required: i_ready drops after 4 bundles (count=8); no further entries are written.
   - Then o_ready=1 for one cycle: count=7, i_ready stays 0. Second pop: count=6, i_ready=1.
5. Violation: with i_ready=0, drive i_valid=2'b11 -> o_overflow=1, count unchanged, FIFO contents intact. o_overflow remains 1 until rst.
6. Wrap and counter:
   - Stimulus: stream 20 instructions with random o_ready through the D=8 FIFO.
   - Required: exact in-order output across pointer wrap.
   - Preload o_cnt to 0xFFFFFFFE via force, then pop 3 -> o_cnt=1.
   - Assert rst mid-stream -> o_valid=0 and count=0 the next cycle.

Source files
------------

// File: rtl/difftest_commit_sched_if.sv
// difftest_commit_sched_if: retire bundle in, serialized commit stream out
// master drives retire lanes and consumer ready; slave is the scheduler
interface difftest_commit_sched_if #(
    parameter int W = 2
);
    logic [W-1:0]    i_valid;
    logic [W*30-1:0] i_pc;
    logic [W*32-1:0] i_insn;
    logic [W-1:0]    i_wen;
    logic [W*5-1:0]  i_wnum;
    logic [W*32-1:0] i_wdata;
    logic            i_ready;
    logic            o_valid;
    logic [29:0]     o_pc;
    logic [31:0]     o_insn;
    logic            o_wen;
    logic [4:0]      o_wnum;
    logic [31:0]     o_wdata;
    logic            o_ready;
    logic            o_overflow;
    logic [31:0]     o_cnt;

    modport master (
        output i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, o_ready,
        input  i_ready, o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_overflow, o_cnt
    );

    modport slave (
        input  i_valid, i_pc, i_insn, i_wen, i_wnum, i_wdata, o_ready,
        output i_ready, o_valid, o_pc, o_insn, o_wen, o_wnum, o_wdata, o_overflow, o_cnt
    );
endinterface

// File: rtl/difftest_commit_sched.sv
// difftest_commit_sched: compacts valid retire lanes into an in-order FIFO
// drained one commit per cycle; sticky overflow on push while not ready
module difftest_commit_sched #(
    parameter int CONFIG_P_COMMIT_WIDTH = 1,
    parameter int CONFIG_P_FIFO_DEPTH   = 3
) (
    input logic clk,
    input logic rst,
    difftest_commit_sched_if.slave bus
);
    localparam int W  = 1 << CONFIG_P_COMMIT_WIDTH;
    localparam int D  = 1 << CONFIG_P_FIFO_DEPTH;
    localparam int AW = CONFIG_P_FIFO_DEPTH;
    localparam int PW = CONFIG_P_FIFO_DEPTH + 1;
    localparam logic [PW-1:0] LIM = PW'(D - W);

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } entry_t;

    entry_t        r_mem [D];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_cnt;
    logic [PW-1:0] w_off [W];
    logic [PW-1:0] w_n;
    logic [PW-1:0] w_add;
    logic          w_any;
    logic          w_push;
    logic          w_pop;
    entry_t        w_head;

    // each valid lane lands at wptr plus the number of valid lanes below it
    always_comb begin
        w_n = '0;
        for (int k = 0; k < W; k++) begin
            w_off[k] = w_n;
            w_n = w_n + PW'(bus.i_valid[k]);
        end
    end

    assign w_any          = |bus.i_valid;
    assign bus.i_ready    = r_count <= LIM;
    assign w_push         = w_any && bus.i_ready;
    assign bus.o_valid    = r_count != '0;
    assign w_pop          = bus.o_valid && bus.o_ready;
    assign w_add          = w_push ? w_n : '0;
    assign w_head         = r_mem[r_rptr[AW-1:0]];
    assign bus.o_pc       = w_head.pc;
    assign bus.o_insn     = w_head.insn;
    assign bus.o_wen      = w_head.wen;
    assign bus.o_wnum     = w_head.wnum;
    assign bus.o_wdata    = w_head.wdata;
    assign bus.o_overflow = r_overflow;
    assign bus.o_cnt      = r_cnt;

    always_ff @(posedge clk) begin
        for (int k = 0; k < W; k++)
            if (w_push && bus.i_valid[k])
                r_mem[AW'(r_wptr + w_off[k])] <= {bus.i_pc[k*30 +: 30], bus.i_insn[k*32 +: 32],
                    bus.i_wen[k], bus.i_wnum[k*5 +: 5], bus.i_wdata[k*32 +: 32]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rptr     <= '0;
            r_wptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_rptr     <= r_rptr + PW'(w_pop);
            r_wptr     <= r_wptr + w_add;
            r_count    <= r_count + w_add - PW'(w_pop);
            r_overflow <= r_overflow | (w_any & ~bus.i_ready);
            r_cnt      <= r_cnt + 32'(w_pop);
        end
    end
endmodule

// File: tb/tb_difftest_commit_sched.sv
// tb_difftest_commit_sched: random and directed stimulus against a queue model
module tb_difftest_commit_sched;
    typedef struct {
        logic [29:0] pc;
        logic [31:0] insn;
        logic        wen;
        logic [4:0]  wnum;
        logic [31:0] wdata;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk = 1'b0;
    int tests = 0;
    int fails = 0;
    ent_t q[$];
    logic m_ovf = 1'b0;
    logic [31:0] m_cnt = '0;

    difftest_commit_sched_if #(.W(2)) bus ();
    difftest_commit_sched #(.CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_FIFO_DEPTH(3)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_lane(input int k, input logic [29:0] pc, input logic [31:0] insn,
                            input logic wen, input logic [4:0] wn, input logic [31:0] wd);
        bus.i_pc[k*30 +: 30]    = pc;
        bus.i_insn[k*32 +: 32]  = insn;
        bus.i_wen[k]            = wen;
        bus.i_wnum[k*5 +: 5]    = wn;
        bus.i_wdata[k*32 +: 32] = wd;
    endtask

    task automatic rand_bundle(input logic [1:0] v);
        for (int k = 0; k < 2; k++)
            set_lane(k, 30'($urandom), $urandom, 1'($urandom), 5'($urandom), $urandom);
        bus.i_valid = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.i_valid = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // reference: a queue of retired instructions, filled in lane order
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
        end else begin
            automatic bit rdy = (8 - q.size()) >= 2;
            if (q.size() != 0 && bus.o_ready) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1;
            end
            if (|bus.i_valid) begin
                if (rdy) begin
                    for (int k = 0; k < 2; k++)
                        if (bus.i_valid[k])
                            q.push_back('{bus.i_pc[k*30 +: 30], bus.i_insn[k*32 +: 32], bus.i_wen[k],
                                          bus.i_wnum[k*5 +: 5], bus.i_wdata[k*32 +: 32]});
                end else m_ovf = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk) begin
            check("o_valid", 64'(bus.o_valid), 64'(q.size() != 0));
            check("i_ready", 64'(bus.i_ready), 64'((8 - q.size()) >= 2));
            check("count", 64'(dut.r_count), 64'(q.size()));
            check("o_overflow", 64'(bus.o_overflow), 64'(m_ovf));
            check("o_cnt", 64'(bus.o_cnt), 64'(m_cnt));
            if (q.size() != 0) begin
                check("o_pc", 64'(bus.o_pc), 64'(q[0].pc));
                check("o_insn", 64'(bus.o_insn), 64'(q[0].insn));
                check("o_wen", 64'(bus.o_wen), 64'(q[0].wen));
                check("o_wnum", 64'(bus.o_wnum), 64'(q[0].wnum));
                check("o_wdata", 64'(bus.o_wdata), 64'(q[0].wdata));
            end
        end
    end

    initial begin
        logic [29:0] seq [5];
        int pushed;
        int cyc;
        seq = '{30'hA, 30'hB, 30'hC, 30'hD, 30'hE};
        bus.i_valid = '0;
        bus.o_ready = 1'b0;
        rand_bundle(2'b00);
        repeat (2) @(negedge clk);
        chk = 1'b1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_o_valid", 64'(bus.o_valid), 64'd0);
            check("idle_i_ready", 64'(bus.i_ready), 64'd1);
            check("idle_o_cnt", 64'(bus.o_cnt), 64'd0);
            check("idle_overflow", 64'(bus.o_overflow), 64'd0);
        end
        rand_bundle(2'b10);
        set_lane(1, 30'h100, 32'hDEADBEEF, 1'b1, 5'd3, 32'd5);
        bus.o_ready = 1'b1;
        @(negedge clk);
        bus.i_valid = '0;
        check("cmp_o_valid", 64'(bus.o_valid), 64'd1);
        check("cmp_o_pc", 64'(bus.o_pc), 64'h100);
        check("cmp_o_wnum", 64'(bus.o_wnum), 64'd3);
        check("cmp_o_wdata", 64'(bus.o_wdata), 64'd5);
        @(negedge clk);
        check("cmp_empty", 64'(bus.o_valid), 64'd0);
        check("cmp_o_cnt", 64'(bus.o_cnt), 64'd1);

        do_reset();
        rand_bundle(2'b11);
        set_lane(0, seq[0], 32'h1, 1'b1, 5'd1, 32'h1);
        set_lane(1, seq[1], 32'h2, 1'b1, 5'd2, 32'h2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ord_o_valid", 64'(bus.o_valid), 64'd1);
            check("ord_o_pc", 64'(bus.o_pc), 64'(seq[i]));
            if (i == 0) begin
                rand_bundle(2'b01);
                set_lane(0, seq[2], 32'h3, 1'b0, 5'd0, 32'h3);
            end else if (i == 1) begin
                rand_bundle(2'b11);
                set_lane(0, seq[3], 32'h4, 1'b1, 5'd4, 32'h4);
                set_lane(1, seq[4], 32'h5, 1'b1, 5'd5, 32'h5);
            end else bus.i_valid = '0;
        end
        @(negedge clk);
        check("ord_empty", 64'(bus.o_valid), 64'd0);
        check("ord_o_cnt", 64'(bus.o_cnt), 64'd5);

        do_reset();
        bus.o_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            rand_bundle(2'b11);
            @(negedge clk);
            check("bp_i_ready", 64'(bus.i_ready), 64'(b < 3));
        end
        check("bp_count", 64'(dut.r_count), 64'd8);
        rand_bundle(2'b11);
        @(negedge clk);
        bus.i_valid = '0;
        check("viol_overflow", 64'(bus.o_overflow), 64'd1);
        check("viol_count", 64'(dut.r_count), 64'd8);
        bus.o_ready = 1'b1;
        @(negedge clk);
        check("pop1_count", 64'(dut.r_count), 64'd7);
        check("pop1_i_ready", 64'(bus.i_ready), 64'd0);
        @(negedge clk);
        check("pop2_count", 64'(dut.r_count), 64'd6);
        check("pop2_i_ready", 64'(bus.i_ready), 64'd1);
        repeat (6) @(negedge clk);
        check("drain_empty", 64'(bus.o_valid), 64'd0);
        check("drain_sticky", 64'(bus.o_overflow), 64'd1);
        check("drain_o_cnt", 64'(bus.o_cnt), 64'd8);

        do_reset();
        pushed = 0;
        cyc = 0;
        while (!(pushed >= 20 && q.size() == 0 && bus.i_valid == '0) && cyc < 500) begin
            bus.o_ready = 1'($urandom_range(0, 1));
            if (pushed < 20 && bus.i_ready) begin
                rand_bundle(2'($urandom));
                pushed += int'(bus.i_valid[0]) + int'(bus.i_valid[1]);
            end else bus.i_valid = '0;
            @(negedge clk);
            cyc++;
        end
        check("stream_timeout", 64'(cyc < 500), 64'd1);
        check("stream_o_cnt", 64'(bus.o_cnt), 64'(pushed));
        check("stream_overflow", 64'(bus.o_overflow), 64'd0);

        for (int i = 0; i < 300; i++) begin
            bus.o_ready = 1'($urandom_range(0, 3) != 0);
            rand_bundle(($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00);
            @(negedge clk);
        end

        do_reset();
        bus.o_ready = 1'b0;
        @(posedge clk);
        #1;
        force dut.r_cnt = 32'hFFFFFFFE;
        m_cnt = 32'hFFFFFFFE;
        @(posedge clk);
        #1;
        release dut.r_cnt;
        @(negedge clk);
        rand_bundle(2'b11);
        bus.o_ready = 1'b1;
        @(negedge clk);
        rand_bundle(2'b01);
        @(negedge clk);
        bus.i_valid = '0;
        repeat (2) @(negedge clk);
        check("wrap_o_cnt", 64'(bus.o_cnt), 64'd1);
        check("wrap_empty", 64'(bus.o_valid), 64'd0);

        bus.o_ready = 1'b0;
        rand_bundle(2'b11);
        @(negedge clk);
        bus.i_valid = '0;
        check("mid_o_valid", 64'(bus.o_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_o_valid", 64'(bus.o_valid), 64'd0);
        check("rst_count", 64'(dut.r_count), 64'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
